// File: rtl/sram_port_arbiter.sv
// Arbitrates a fetch port (read-only) and a load/store port onto one
// single-ported SRAM, sequencing ram_we/ram_oe and the bidirectional data bus.
module sram_port_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int DATA_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic [1:0]        dbg_state   // 0 = IDLE, 1 = RD1, 2 = RD2, 3 = WR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    WR   = 2'd3
  } state_e;

  // Handshake: a requester holds req (and its address/data) until it sees a
  // one-cycle gnt; reads later return one valid pulse with rdata, writes none.

  state_e              state_q, state_d;
  logic                f_gnt_q, f_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                f_valid_q, f_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_oe_q, ram_oe_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                port_d_q, port_d_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                last_d_q, last_d_d;
  logic                take_d;

  always_comb begin
    state_d    = state_q;
    f_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    f_valid_d  = 1'b0;
    d_valid_d  = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    ram_we_d   = 1'b0;
    ram_oe_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    port_d_d   = port_d_q;
    wdata_d    = wdata_q;
    last_d_d   = last_d_q;
    take_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // last_d_q low means the data port is owed the next tie
          take_d     = d_req && (!f_req || (DATA_PRIORITY != 0) || !last_d_q);
          last_d_d   = take_d;
          port_d_d   = take_d;
          wdata_d    = d_wdata;
          ram_addr_d = take_d ? d_addr : f_addr;
          f_gnt_d    = !take_d;
          d_gnt_d    = take_d;
          if (take_d && d_we) begin
            state_d  = WR;
            ram_we_d = 1'b1;
          end else begin
            state_d  = RD1;
            ram_oe_d = 1'b1;
          end
        end
      end
      RD1: begin
        state_d  = RD2;
        ram_oe_d = 1'b1;
      end
      RD2: begin
        state_d = IDLE;
        if (port_d_q) begin
          d_valid_d = 1'b1;
          d_rdata_d = ram_data;
        end else begin
          f_valid_d = 1'b1;
          f_rdata_d = ram_data;
        end
      end
      WR: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      f_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      ram_addr_q <= '0;
      port_d_q   <= 1'b0;
      wdata_q    <= '0;
      last_d_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_gnt_q    <= f_gnt_d;
      d_gnt_q    <= d_gnt_d;
      f_valid_q  <= f_valid_d;
      d_valid_q  <= d_valid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
      ram_we_q   <= ram_we_d;
      ram_oe_q   <= ram_oe_d;
      ram_addr_q <= ram_addr_d;
      port_d_q   <= port_d_d;
      wdata_q    <= wdata_d;
      last_d_q   <= last_d_d;
    end
  end

  // Bus drive is tied to WR alone; IDLE always separates a read's RD2 from a WR.
  assign ram_data  = (state_q == WR) ? wdata_q : {DATA_W{1'bz}};

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_valid   = f_valid_q;
  assign d_valid   = d_valid_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-port controller and arbiter for the single-ported 16-bit, 256K-word SRAM (we/oe/addr, bidirectional data bus).
- Shares the SRAM between the instruction-fetch path (read-only) and the load/store data path (read/write).
- Sequences ram_we and ram_oe, and owns the tristate drive of the data bus.
- Sits between instr_addr_reg/control_unit and the SRAM pins.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- DATA_PRIORITY, 0. 0 = round-robin between ports on a tie; 1 = data port always wins a tie.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request; held with f_addr until f_gnt.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  one-cycle pulse: fetch request accepted.
- f_valid  out  1  one-cycle pulse: f_rdata is valid.
- f_rdata  out  DATA_W  fetch read data; holds its value between pulses.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: d_rdata is valid (reads only).
- d_rdata  out  DATA_W  data read data; holds its value between pulses.
- ram_we  out  1  SRAM write enable, registered.
- ram_oe  out  1  SRAM output enable, registered.
- ram_addr  out  ADDR_W  SRAM address, registered.
- ram_data  inout  DATA_W  SRAM data bus; driven only in WR, otherwise high-Z.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE; ram_we, ram_oe, f_gnt, d_gnt, f_valid, d_valid, busy all 0; ram_addr 0; f_rdata and d_rdata 0; bus released; round-robin pointer set so the data port wins the first tie.
- States:
  - IDLE: ram_we=0, ram_oe=0, bus high-Z.
  - RD1: ram_oe=1, ram_we=0.
  - RD2: ram_oe=1, ram_we=0.
  - WR: ram_we=1, ram_oe=0, controller drives ram_data.
- Arbitration happens only in IDLE, sampling f_req and d_req at the clock edge.
  - A single requester wins.
  - On a tie: with DATA_PRIORITY=1 the data port wins; with DATA_PRIORITY=0 the port not granted last wins.
  - The pointer updates on every grant.
- Grant edge (end of IDLE cycle T):
  - ram_addr <= winner's address.
  - Winning gnt <= 1 for exactly cycle T+1.
  - Winner's port, d_we and d_wdata are latched internally.
  - Next state is RD1 for a read, or WR for a data write.
- Read timing:
  - Cycle T+1 (RD1): SRAM captures memory[ram_addr] at the end of T+1.
  - Cycle T+2 (RD2): SRAM drives the bus; controller samples ram_data at the end of T+2 into the port's rdata.
  - Cycle T+3: port's valid=1; state is IDLE.
  - Latency: request seen in T, data valid in T+3. Occupancy is 3 cycles, so the next grant edge is at the end of T+3.
- Write timing:
  - Cycle T+1 (WR): ram_we=1, ram_data=latched wdata; SRAM writes at the end of T+1.
  - Next state IDLE. Occupancy is 2 cycles; no valid pulse for writes.
- No bus contention: the controller's drive enable is (state==WR) only. ram_oe=0 in every IDLE cycle, so there is at least one idle cycle between a read's RD2 and any WR.
- Request behaviour:
  - A request deasserted before its grant is dropped with no side effects.
  - A requester still asserting req after gnt is treated as a new request.
  - f_valid and d_valid are never high in the same cycle.
- Reset mid-operation:
  - rst forces IDLE at that edge.
  - A WR cycle coinciding with rst still writes; its gnt has already been issued.
  - A read interrupted in RD1/RD2 produces no valid pulse.
  - rst overrides any pending requests.
- Address and data are used verbatim; there is no wrap or offset arithmetic. Address 2^ADDR_W-1 is legal.

Test Plan:
1. Reset: rst=1 for 2 cycles with f_req=d_req=1 -> all outputs 0, bus high-Z, no gnt. Release -> d_gnt in the cycle after the first IDLE sample.
2. Write then read: d_req, d_we=1, d_addr=0x00010, d_wdata=0xBEEF -> d_gnt 1 cycle later, ram_we high 1 cycle. Then d_req read of 0x00010 -> d_valid with d_rdata=0xBEEF exactly 3 cycles after the sample.
3. Fetch stream: f_req held high, f_addr stepping 0x3FFFE, 0x3FFFF, 0x00000 after each gnt -> f_gnt every 3 cycles; f_valid returns the preloaded words in order with no data-port activity.
4. Round-robin, DATA_PRIORITY=0: f_req and d_req both held continuously -> grants alternate d,f,d,f; neither port is granted twice consecutively.
5. Fixed priority, DATA_PRIORITY=1: d_req held continuously plus f_req -> f_gnt never asserts until d_req drops, then f_gnt on the next IDLE sample.
6. Reset mid-read: assert rst during RD2 -> no d_valid or f_valid, next cycle IDLE with ram_oe=0; a write with rst in its WR cycle is visible on a later read.
